clk_enable_synth: RTL and testbench
===================================

Name: clk_enable_synth

Overview:
- Parametrised multi-channel fractional clock-enable synthesiser. Soft successor to the fixed single-output pixel-clock PLL wrapper.
- Runs entirely in the `refclk` domain. Each channel is a phase accumulator producing a one-cycle enable strobe and a registered square wave at `inc/2^ACC_W × f_refclk`.
- Rates are reprogrammable at run time with glitch-free, boundary-aligned updates and a per-channel locked indication.
- Feeds VGA pixel enables, game-tick enables and audio/sample enables without extra PLLs.

Parameters:
- NUM_CH, 2, number of independent channels (1..8).
- ACC_W, 32, accumulator/increment width in bits (8..32).
- DEF_INC, 2164527109, reset increment for every channel (≈25.198 MHz enable at 50 MHz refclk).
- LOCK_CNT, 16, consecutive strobes at a stable increment before locked asserts (≥1).

Ports:
- refclk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  config write request.
- cfg_ch  in  3  target channel index.
- cfg_inc  in  ACC_W  new increment.
- cfg_ready  out  1  write accepted when cfg_valid & cfg_ready.
- cfg_err  out  1  one-cycle pulse on out-of-range cfg_ch.
- strobe  out  NUM_CH  per-channel one-cycle enable.
- clk_out  out  NUM_CH  per-channel registered square wave (accumulator MSB).
- locked  out  NUM_CH  per-channel rate-stable flag.

Behaviour:
- Reset (async assert, sync release) sets:
  - acc=0, inc=DEF_INC for all channels;
  - no pending updates;
  - strobe=0, clk_out=0, locked=0;
  - cfg_ready=1, cfg_err=0.
- Per cycle, for each channel with inc≠0:
  - acc <= (acc+inc) mod 2^ACC_W;
  - strobe registered from the carry-out, so strobe is high exactly the cycle after the wrapping edge;
  - clk_out = acc[ACC_W-1] registered;
  - average strobe rate = inc/2^ACC_W per cycle; fractional ratios produce a jittered, deterministic spacing.
- inc ≥ 2^(ACC_W-1) is legal for strobe. clk_out duty is then undefined, and the driver must not use it.
- inc=0: acc holds, strobe=0, clk_out holds, locked=0.
- Config handshake:
  - A write is accepted on cfg_valid & cfg_ready with cfg_ch<NUM_CH. It stores a pending increment for that channel.
  - cfg_ready drops the following cycle and stays low while any channel has a pending update.
  - cfg_valid while cfg_ready=0 is ignored silently.
  - cfg_ch≥NUM_CH while cfg_ready=1: nothing stored, cfg_err pulses the next cycle, cfg_ready stays 1.
- Update application:
  - If the channel's current inc≠0, the pending value loads in the cycle its carry occurs. The wrapping addition uses the old inc; the new inc is used from the next addition. acc is not cleared, so phase is continuous.
  - If current inc=0, the pending value loads the cycle after acceptance.
  - Pending clears on load; cfg_ready rises the cycle after the last pending clears.
- Locked:
  - Per-channel counter, saturating at LOCK_CNT, width clog2(LOCK_CNT+1).
  - Increments on each strobe.
  - Cleared on update load, on inc=0, and on reset.
  - locked=1 iff counter==LOCK_CNT and no pending update on that channel.
- Channels are fully independent except for the shared cfg_ready.
- Reset mid-operation aborts pending updates and restores DEF_INC.

Optional Feature:
- Macro SYNC_RESTART_EN.
- Defined:
  - Adds input port `sync_restart` (1 bit).
  - A high cycle clears all accumulators to 0 on the next edge and forces strobe=0 that cycle.
  - It clears all lock counters and loads any pending increments immediately. cfg_ready returns to 1 the following cycle.
  - This gives phase-aligned restart of all channels, e.g. at VGA frame start.
- Undefined: port absent; no restart logic.

Test Plan:
- ACC_W=8, NUM_CH=2, DEF_INC=64, LOCK_CNT=4, reset release:
  - strobe[0] first high after 4th edge, then every 4 cycles;
  - clk_out 2 low / 2 high;
  - locked[0] rises with 4th strobe (cycle 16).
- Write ch1 inc=32 mid-period:
  - old 4-cycle spacing until the next ch1 wrap, then 8-cycle spacing;
  - locked[1] falls at load and rises after 4 new strobes (32 cycles);
  - ch0 undisturbed.
- Write ch0 inc=0: strobe[0] stops after the pending wrap. Then write inc=64: loads the next cycle and strobes resume from the held acc.
- Fractional inc=96: exactly 3 strobes per 8 cycles, spacings following 3,3,2 repeating from acc=0.
- cfg_ch=5 → cfg_err one-cycle pulse, cfg_ready stays 1, no rate change. cfg_valid while cfg_ready=0 → ignored, rates unchanged.
- With SYNC_RESTART_EN: pulse sync_restart → all acc=0 next cycle, strobes suppressed that cycle, locked all 0, both channels realigned.

Source files
------------

// File: rtl/clk_enable_synth.sv
// Multi-channel fractional clock-enable synthesiser: one phase accumulator per channel
// with boundary-aligned rate updates and lock tracking. Optional SYNC_RESTART_EN adds sync_restart.
module clk_enable_synth #(
    parameter int unsigned     NUM_CH   = 2,
    parameter int unsigned     ACC_W    = 32,
    parameter longint unsigned DEF_INC  = 64'd2164527109,
    parameter int unsigned     LOCK_CNT = 16
) (
    input  logic              refclk,
    input  logic              rst_n,
`ifdef SYNC_RESTART_EN
    input  logic              sync_restart,
`endif
    input  logic              cfg_valid,
    input  logic [2:0]        cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    output logic              cfg_ready,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] strobe,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] locked
);

    localparam int unsigned      CNT_W   = $clog2(LOCK_CNT + 1);
    localparam logic [ACC_W-1:0] INC_RST = ACC_W'(DEF_INC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CNT);

    logic [ACC_W-1:0] acc      [NUM_CH];
    logic [ACC_W-1:0] acc_n    [NUM_CH];
    logic [ACC_W-1:0] inc      [NUM_CH];
    logic [ACC_W-1:0] inc_n    [NUM_CH];
    logic [ACC_W-1:0] pinc     [NUM_CH];
    logic [ACC_W-1:0] pinc_n   [NUM_CH];
    logic [CNT_W-1:0] cnt      [NUM_CH];
    logic [CNT_W-1:0] cnt_n    [NUM_CH];
    logic [ACC_W:0]   sum      [NUM_CH];
    logic [NUM_CH-1:0] pend, pend_n;
    logic [NUM_CH-1:0] strobe_n, clk_out_n, locked_n;
    logic              cfg_ready_n, cfg_err_n;
    logic              cfg_hit, ch_ok, restart;

`ifdef SYNC_RESTART_EN
    assign restart = sync_restart;
`else
    assign restart = 1'b0;
`endif

    // Next-state: accumulate, apply pending rates at wrap (or at once when idle), track lock.
    always_comb begin
        cfg_hit   = cfg_valid && cfg_ready;
        ch_ok     = int'(cfg_ch) < int'(NUM_CH);
        cfg_err_n = cfg_hit && !ch_ok;
        strobe_n  = '0;
        clk_out_n = '0;
        locked_n  = '0;
        pend_n    = pend;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            sum[i]    = {1'b0, acc[i]} + {1'b0, inc[i]};
            acc_n[i]  = sum[i][ACC_W-1:0];
            inc_n[i]  = inc[i];
            pinc_n[i] = pinc[i];
            cnt_n[i]  = cnt[i];
            strobe_n[i] = sum[i][ACC_W];

            if (inc[i] == '0) begin
                cnt_n[i] = '0;
            end else if (sum[i][ACC_W] && (cnt[i] != CNT_MAX)) begin
                cnt_n[i] = cnt[i] + CNT_W'(1);
            end

            // Idle channels take a new rate immediately; running ones only at a wrap.
            if (pend[i] && ((inc[i] == '0) || sum[i][ACC_W])) begin
                inc_n[i]  = pinc[i];
                pend_n[i] = 1'b0;
                cnt_n[i]  = '0;
            end

            if (restart) begin
                acc_n[i]    = '0;
                strobe_n[i] = 1'b0;
                cnt_n[i]    = '0;
                if (pend[i]) begin
                    inc_n[i] = pinc[i];
                end
                pend_n[i] = 1'b0;
            end

            if (cfg_hit && ch_ok && (int'(cfg_ch) == i)) begin
                pend_n[i] = 1'b1;
                pinc_n[i] = cfg_inc;
            end

            clk_out_n[i] = acc_n[i][ACC_W-1];
            locked_n[i]  = (cnt_n[i] == CNT_MAX) && !pend_n[i];
        end
        cfg_ready_n = ~|pend_n;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                acc[i]  <= '0;
                inc[i]  <= INC_RST;
                pinc[i] <= '0;
                cnt[i]  <= '0;
            end
            pend      <= '0;
            strobe    <= '0;
            clk_out   <= '0;
            locked    <= '0;
            cfg_ready <= 1'b1;
            cfg_err   <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                acc[i]  <= acc_n[i];
                inc[i]  <= inc_n[i];
                pinc[i] <= pinc_n[i];
                cnt[i]  <= cnt_n[i];
            end
            pend      <= pend_n;
            strobe    <= strobe_n;
            clk_out   <= clk_out_n;
            locked    <= locked_n;
            cfg_ready <= cfg_ready_n;
            cfg_err   <= cfg_err_n;
        end
    end

endmodule

// File: tb/tb_clk_enable_synth.sv
// Randomised bench for clk_enable_synth (ACC_W=8, NUM_CH=2, DEF_INC=64, LOCK_CNT=4)
// against an integer-arithmetic reference model plus directed timing checks.
module tb_clk_enable_synth;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       cfg_valid;
    logic [2:0] cfg_ch;
    logic [7:0] cfg_inc;
    logic       cfg_ready, cfg_err;
    logic [1:0] strobe, clk_out, locked;
`ifdef SYNC_RESTART_EN
    logic       sync_restart = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model state, plain integers
    int         m_acc [2];
    int         m_inc [2];
    int         m_pinc[2];
    bit         m_pend[2];
    int         m_cnt [2];
    logic [1:0] m_strobe, m_clk, m_locked;
    logic       m_ready, m_err;

    clk_enable_synth #(
        .NUM_CH(2), .ACC_W(8), .DEF_INC(64), .LOCK_CNT(4)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
`ifdef SYNC_RESTART_EN
        .sync_restart(sync_restart),
`endif
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .strobe    (strobe),
        .clk_out   (clk_out),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_acc[c] = 0; m_inc[c] = 64; m_pinc[c] = 0; m_pend[c] = 0; m_cnt[c] = 0;
        end
        m_strobe = '0; m_clk = '0; m_locked = '0; m_ready = 1'b1; m_err = 1'b0;
    endtask

    // One refclk edge of the behavioural model, using the inputs present before the edge.
    task automatic model_step();
        bit rdy;
        bit rs;
        int total;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rdy = m_ready;
        rs  = 1'b0;
`ifdef SYNC_RESTART_EN
        rs = sync_restart;
`endif
        for (int c = 0; c < 2; c++) begin
            if (rs) begin
                m_acc[c] = 0; m_strobe[c] = 1'b0; m_cnt[c] = 0;
                if (m_pend[c]) begin m_inc[c] = m_pinc[c]; m_pend[c] = 0; end
            end else if (m_inc[c] == 0) begin
                m_strobe[c] = 1'b0; m_cnt[c] = 0;
                if (m_pend[c]) begin m_inc[c] = m_pinc[c]; m_pend[c] = 0; end
            end else begin
                total       = m_acc[c] + m_inc[c];
                m_acc[c]    = total % 256;
                m_strobe[c] = (total >= 256);
                if (total >= 256) begin
                    if (m_pend[c]) begin
                        m_inc[c] = m_pinc[c]; m_pend[c] = 0; m_cnt[c] = 0;
                    end else if (m_cnt[c] < 4) begin
                        m_cnt[c]++;
                    end
                end
            end
        end
        m_err = 1'b0;
        if (cfg_valid && rdy) begin
            if (cfg_ch < 3'd2) begin
                m_pend[cfg_ch] = 1; m_pinc[cfg_ch] = int'(cfg_inc);
            end else begin
                m_err = 1'b1;
            end
        end
        m_ready = !(m_pend[0] || m_pend[1]);
        for (int c = 0; c < 2; c++) begin
            m_clk[c]    = (m_acc[c] >= 128);
            m_locked[c] = (m_cnt[c] == 4) && !m_pend[c];
        end
    endtask

    task automatic step();
        @(posedge refclk);
        model_step();
        #1;
        cyc++;
        check("strobe",    32'(strobe),    32'(m_strobe));
        check("clk_out",   32'(clk_out),   32'(m_clk));
        check("locked",    32'(locked),    32'(m_locked));
        check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
        check("cfg_err",   32'(cfg_err),   32'(m_err));
    endtask

    task automatic write_cfg(input logic [2:0] ch, input logic [7:0] val);
        cfg_valid = 1'b1; cfg_ch = ch; cfg_inc = val;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        for (int n = 0; n < 40 && !cfg_ready; n++) step();
        check(tag, 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        int first_strobe;
        int lock_rise;
        int p;
        int strobes;
        bit exp_s;
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0;
        model_reset();
        #12;
        check("rst_strobe", 32'(strobe),    32'd0);
        check("rst_clk",    32'(clk_out),   32'd0);
        check("rst_locked", 32'(locked),    32'd0);
        check("rst_ready",  32'(cfg_ready), 32'd1);
        check("rst_err",    32'(cfg_err),   32'd0);
        @(posedge refclk); #1;
        rst_n = 1'b1;

        // default rate: strobe every 4 cycles, lock with the 4th strobe
        first_strobe = -1; lock_rise = -1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (strobe[0] && first_strobe < 0) first_strobe = cyc;
            if (locked[0] && lock_rise < 0) lock_rise = cyc;
        end
        check("first_strobe_cycle", 32'(first_strobe), 32'd4);
        check("lock_rise_cycle",    32'(lock_rise),    32'd16);

        // ch1 -> 96 applied at its next wrap; a write during the pending window is dropped
        write_cfg(3'd1, 8'd96);
        write_cfg(3'd0, 8'd200);
        p = cyc;
        for (int n = 0; n < 40 && !cfg_ready; n++) begin step(); p = cyc; end
        check("load_cycle",   32'(p),         32'd24);
        check("load_wrap",    32'(strobe[1]), 32'd1);
        strobes = 0;
        for (int k = 1; k <= 24; k++) begin
            step();
            exp_s = ((k * 96) / 256) != (((k - 1) * 96) / 256);
            check("frac96_strobe", 32'(strobe[1]), 32'(exp_s));
            if (strobe[1]) strobes++;
        end
        check("frac96_count", 32'(strobes), 32'd9);

        // out-of-range channel
        write_cfg(3'd5, 8'd10);
        check("bad_ch_err",   32'(cfg_err),   32'd1);
        check("bad_ch_ready", 32'(cfg_ready), 32'd1);
        step();
        check("bad_ch_err_pulse", 32'(cfg_err), 32'd0);

        // stop ch0, then restart from the held accumulator
        write_cfg(3'd0, 8'd0);
        wait_ready("stop_ready_timeout");
        for (int k = 0; k < 10; k++) step();
        write_cfg(3'd0, 8'd64);
        step();
        check("resume_ready", 32'(cfg_ready), 32'd1);

        // random traffic with an occasional mid-run reset
        for (int k = 0; k < 3000; k++) begin
            cfg_valid = ($urandom % 4) == 0;
            cfg_ch    = (($urandom % 8) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom % 2);
            case ($urandom % 5)
                0: cfg_inc = 8'd0;
                1: cfg_inc = 8'd32;
                2: cfg_inc = 8'd64;
                3: cfg_inc = 8'd96;
                default: cfg_inc = 8'($urandom % 256);
            endcase
            rst_n = !(k == 1500);
`ifdef SYNC_RESTART_EN
            sync_restart = ($urandom % 64) == 0;
`endif
            step();
        end
        cfg_valid = 1'b0; rst_n = 1'b1;
`ifdef SYNC_RESTART_EN
        sync_restart = 1'b0;
`endif
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
